// File: rtl/det_host_ctrl.sv
// det_host_ctrl -- initiator side of the determinant engine Start/Ack protocol.
//
// Collects an 8x8 one-bit matrix as eight 8-bit rows, presents it on
// input_arr, runs one Start/Ack exchange with the engine and hands the
// signed determinant to a downstream consumer.
//
// Ports:
//   Clk, Reset            clock, synchronous active-high reset
//   row_data/row_valid    row stream in; row_ready = block will take a row
//   input_arr             assembled matrix, row k at [8k+7:8k]
//   Start, Ack            handshake outputs to the engine
//   q_Enter, q_Done, det  engine state flags and result
//   result/result_valid   captured determinant, held until res_ack
//   timeout               sticky abort flag, cleared by the next frame's row 0
//   busy                  an engine exchange is in progress (ARM/WAIT/ACK)
module det_host_ctrl #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int ROWS           = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [7:0]  row_data,
  input  logic        row_valid,
  output logic        row_ready,
  output logic [63:0] input_arr,
  output logic        Start,
  output logic        Ack,
  input  logic        q_Enter,
  input  logic        q_Done,
  input  logic [31:0] det,
  output logic [31:0] result,
  output logic        result_valid,
  input  logic        res_ack,
  output logic        timeout,
  output logic        busy
);

  typedef enum logic [5:0] {
    S_IDLE = 6'b000001,
    S_FILL = 6'b000010,
    S_ARM  = 6'b000100,
    S_WAIT = 6'b001000,
    S_ACK  = 6'b010000,
    S_HOLD = 6'b100000
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  row_cnt;
  logic [2:0]  row_idx;
  logic [15:0] to_cnt;
  logic        to_hit;
  logic        row_take, arm_entry, capture, abort;
  logic [63:0] arr_q;
  logic [31:0] result_q;
  logic        timeout_q;

  // Last cycle of the ARM+WAIT budget: the counter started at 0 on ARM entry.
  assign to_hit = (to_cnt == 16'(TIMEOUT_CYCLES - 1));

  // Row 0 is always written from IDLE, so a frame aborted by reset or
  // timeout restarts cleanly at the bottom of input_arr.
  assign row_idx = (state == S_IDLE) ? 3'd0 : row_cnt[2:0];

  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    row_take  = 1'b0;
    arm_entry = 1'b0;
    capture   = 1'b0;
    abort     = 1'b0;
    case (state)
      S_IDLE: if (row_valid) begin
        row_take  = 1'b1;
        state_nxt = S_FILL;
      end
      S_FILL: if (row_valid) begin
        row_take = 1'b1;
        if (row_cnt == 4'(ROWS - 1)) begin
          arm_entry = 1'b1;
          state_nxt = S_ARM;
        end
      end
      // Start is high throughout ARM, so q_Enter here means the engine has
      // seen Start while in ENTER.
      S_ARM: begin
        if (to_hit) begin
          abort     = 1'b1;
          state_nxt = S_IDLE;
        end else if (q_Enter) begin
          state_nxt = S_WAIT;
        end
      end
      // A q_Done landing on the final budget cycle still counts as success.
      S_WAIT: begin
        if (q_Done) begin
          capture   = 1'b1;
          state_nxt = S_ACK;
        end else if (to_hit) begin
          abort     = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_ACK:   if (!q_Done) state_nxt = S_HOLD;
      S_HOLD:  if (res_ack) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      row_cnt   <= '0;
      to_cnt    <= '0;
      arr_q     <= '0;
      result_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (row_take) begin
        arr_q[{row_idx, 3'b000} +: 8] <= row_data;
        row_cnt                       <= {1'b0, row_idx} + 4'd1;
      end
      if (row_take && state == S_IDLE) timeout_q <= 1'b0;
      else if (abort)                  timeout_q <= 1'b1;
      if (arm_entry)                                to_cnt <= '0;
      else if (state == S_ARM || state == S_WAIT)  to_cnt <= to_cnt + 16'd1;
      if (capture) result_q <= det;
    end
  end

  // Handshake outputs are decoded from state; gating with Reset keeps them
  // low during the reset cycle itself, including a reset that lands mid-ACK.
  assign row_ready    = !Reset && (state == S_IDLE || state == S_FILL);
  assign Start        = !Reset && (state == S_ARM);
  assign Ack          = !Reset && (state == S_ACK);
  assign result_valid = !Reset && (state == S_HOLD);
  assign busy         = !Reset && (state == S_ARM || state == S_WAIT || state == S_ACK);
  assign input_arr    = arr_q;
  assign result       = result_q;
  assign timeout      = timeout_q;

endmodule

// File: doc/det_host_ctrl.md
Name: det_host_ctrl

Overview:
- Initiator side of the determinant engine's Start/Ack protocol.
- Accepts an 8x8 one-bit matrix as eight 8-bit rows over a valid/ready stream and assembles the 64-bit input_arr bus.
- Asserts Start, waits for the engine's q_Done, captures det, returns Ack.
- Presents the signed result to a downstream consumer with its own valid/ack handshake.
- Sits between the board-level input logic (switches/UART) and the determinant engine.

Parameters:
TIMEOUT_CYCLES, 4096, max cycles in ARM+WAIT before abort; counter width 16, legal range 1..65535
ROWS, 8, rows per frame; fixed, 8-bit rows

Ports:
Clk  in  1  system clock, all logic on rising edge
Reset  in  1  synchronous, active-high reset
row_data  in  8  matrix row; row k lands in input_arr[8k+7:8k]
row_valid  in  1  row_data valid
row_ready  out  1  block accepts a row this cycle
input_arr  out  64  assembled matrix to engine, stable ARM through ACK
Start  out  1  to engine start input
Ack  out  1  to engine ack input
q_Enter  in  1  engine state flag ENTER
q_Done  in  1  engine state flag DONE
det  in  32  engine result, two's complement
result  out  32  captured determinant
result_valid  out  1  result held valid until res_ack
res_ack  in  1  consumer accepts result
timeout  out  1  sticky abort flag, cleared at next frame's first row
busy  out  1  high in ARM, WAIT, ACK

Behaviour:
- Reset (sync, 1 cycle) puts state in IDLE and clears all outputs and counters: input_arr=0, result=0, row count=0, timeout counter=0, Start=Ack=row_ready=result_valid=timeout=busy=0. Reset has priority over every event, including mid-ACK.
- States, one-hot: IDLE, FILL, ARM, WAIT, ACK, HOLD.
- IDLE: row_ready=1. On row_valid, store row 0, set row count=1, clear timeout, go to FILL.
- FILL: row_ready=1. Each row_valid&row_ready cycle stores the row at index = row count, then increments the count.
  - On the 8th row (count 7->8), go to ARM next cycle.
  - No rows are dropped. row_ready is 0 in every state other than IDLE/FILL.
- ARM: Start=1, held while q_Enter=0 (engine may still be in I).
  - When Start=1 and q_Enter=1 in the same cycle, go to WAIT. Start drops the next cycle, so the engine sees Start for at least 1 cycle in ENTER.
- WAIT: Start=0. On q_Done=1, capture result<=det and go to ACK.
- ACK: Ack=1 until q_Done samples 0, then go to HOLD. Ack deasserts in the same transition, so there is at most one cycle of Ack after the engine leaves DONE.
- HOLD: result_valid=1. On res_ack, clear result_valid and go to IDLE. result stays unchanged until the next capture.
- Latency: first Start is 1 cycle after the 8th row accepted. result_valid rises 2 cycles after q_Done is first seen.
- Timeout:
  - The counter is cleared on entry to ARM and increments each cycle in ARM/WAIT.
  - On reaching TIMEOUT_CYCLES: set timeout=1, drop Start, go to IDLE, leave result_valid=0, leave result unchanged.
  - A q_Done that coincides with the timeout cycle wins: capture, no timeout.
- res_ack outside HOLD is ignored. row_valid in ARM/WAIT/ACK/HOLD is ignored and not stored.
- busy = ARM|WAIT|ACK.
- det is passed through bit-exact; no sign manipulation.

Test Plan:
1. Reset, feed rows 0x01,0x02,0x04,...,0x80 back-to-back -> input_arr=64'h8040201008040201, Start rises 1 cycle after the 8th row; engine model returns det=1 -> result=32'h00000001, result_valid=1 until res_ack.
2. Rows with row_valid gaps of 3 cycles -> exactly 8 rows stored in order, row_ready=0 once in ARM, 9th row_valid ignored.
3. Engine model holds q_Enter=0 for 5 cycles after Start -> Start stays high 5 cycles, then drops 1 cycle after q_Enter=1.
4. Engine never asserts q_Done, TIMEOUT_CYCLES=16 -> timeout=1 after 16 cycles in ARM+WAIT, Start=0, state IDLE, result_valid=0.
5. det=32'hFFFFFFF9 (-7) -> result=32'hFFFFFFF9. Ack high while q_Done=1, low the cycle after q_Done=0. res_ack held 4 cycles -> result_valid low after the first cycle.
6. Assert Reset in WAIT with q_Done rising in the same cycle -> no capture, all outputs 0, next frame starts from row 0.
